// File: rtl/hack_cpu_if.sv
// hack_cpu_if: instruction/data memory bus between the Hack CPU and its memories
interface hack_cpu_if;
   logic [15:0] inM;
   logic [15:0] instruction;
   logic [15:0] outM;
   logic        writeM;
   logic [15:0] addressM;
   logic [15:0] pc;
   modport master (input inM, instruction, output outM, writeM, addressM, pc);
   modport slave (output inM, instruction, input outM, writeM, addressM, pc);
endinterface

// File: rtl/hack_cpu.sv
// hack_cpu: single-cycle Hack CPU with A, D and PC registers and combinational ALU
module hack_cpu (
   input logic clk,
   input logic reset,
   hack_cpu_if.master bus
);
   logic [15:0] a = '0;
   logic [15:0] d = '0;
   logic [15:0] pc_q = '0;
   logic [15:0] ins, x0, x, y0, y, r, alu;
   logic        c_ins, zr, ng, jmp;
   assign ins   = bus.instruction;
   assign c_ins = ins[15];
   assign x0    = ins[11] ? 16'h0 : d;
   assign x     = ins[10] ? ~x0 : x0;
   assign y0    = ins[9] ? 16'h0 : (ins[12] ? bus.inM : a);
   assign y     = ins[8] ? ~y0 : y0;
   assign r     = ins[7] ? x + y : x & y;
   assign alu   = ins[6] ? ~r : r;
   assign zr    = alu == 16'h0;
   assign ng    = alu[15];
   assign jmp   = c_ins & ((ng & ins[2]) | (zr & ins[1]) | (~ng & ~zr & ins[0]));
   assign bus.outM     = alu;
   assign bus.writeM   = c_ins & ins[3];
   assign bus.addressM = a;
   assign bus.pc       = pc_q;
   // jump target is the pre-edge A, so a same-cycle A write never redirects the jump
   always_ff @(posedge clk) begin
      a    <= !c_ins ? ins : (ins[5] ? alu : a);
      d    <= (c_ins & ins[4]) ? alu : d;
      pc_q <= reset ? 16'h0 : (jmp ? a : pc_q + 16'h1);
   end
endmodule

// File: tb/tb_hack_cpu.sv
// tb_hack_cpu: scoreboard bench comparing hack_cpu against a behavioural Hack model
module tb_hack_cpu;
   logic clk = 1'b0;
   logic reset = 1'b1;
   hack_cpu_if bus();
   hack_cpu dut (.clk(clk), .reset(reset), .bus(bus));
   always #5 clk = ~clk;
   typedef struct {
      string       tag;
      logic [15:0] v;
      bit          post;
   } exp_t;
   exp_t sb[$];
   int n_cmp = 0;
   int n_err = 0;
   logic [15:0] ma = '0, md = '0, mpc = '0;
   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask
   function automatic logic [15:0] obs(input string t);
      if (t == "outM") return bus.outM;
      if (t == "writeM") return {15'h0, bus.writeM};
      if (t == "pc") return bus.pc;
      return bus.addressM;
   endfunction
   function automatic logic [15:0] ref_alu(input logic [15:0] ins, input logic [15:0] xi, input logic [15:0] yi);
      logic [15:0] xv, yv, o;
      xv = xi;
      yv = yi;
      if (ins[11]) xv = 16'h0;
      if (ins[10]) xv = ~xv;
      if (ins[9]) yv = 16'h0;
      if (ins[8]) yv = ~yv;
      if (ins[7]) o = 16'(xv + yv);
      else o = xv & yv;
      if (ins[6]) o = ~o;
      return o;
   endfunction
   task automatic drain(input bit post);
      exp_t e;
      while (sb.size() > 0 && sb[0].post == post) begin
         e = sb.pop_front();
         chk(e.tag, obs(e.tag), e.v);
      end
   endtask
   task automatic step(input logic [15:0] ins, input logic [15:0] m, input logic rst);
      logic [15:0] r, na, nd, npc;
      logic        j;
      bus.instruction = ins;
      bus.inM = m;
      reset = rst;
      r = ref_alu(ins, md, ins[12] ? m : ma);
      j = ins[15] && ((r[15] && ins[2]) || (r == 16'h0 && ins[1]) || (!r[15] && r != 16'h0 && ins[0]));
      na = ins[15] ? (ins[5] ? r : ma) : ins;
      nd = (ins[15] && ins[4]) ? r : md;
      npc = rst ? 16'h0 : (j ? ma : 16'(mpc + 16'h1));
      if (ins[15]) sb.push_back('{"outM", r, 1'b0});
      sb.push_back('{"writeM", {15'h0, ins[15] & ins[3]}, 1'b0});
      sb.push_back('{"pc", npc, 1'b1});
      sb.push_back('{"addressM", na, 1'b1});
      #1;
      drain(1'b0);
      @(posedge clk);
      #1;
      drain(1'b1);
      ma = na;
      md = nd;
      mpc = npc;
   endtask
   initial begin
      bus.instruction = 16'h0;
      bus.inM = 16'h0;
      #1;
      chk("pwr_pc", bus.pc, 16'h0);
      chk("pwr_a", bus.addressM, 16'h0);
      repeat (3) step(16'h0000, 16'h0, 1'b1);
      step(16'h0001, 16'h0, 1'b0);
      step(16'h0002, 16'h0, 1'b0);
      step(16'h1234, 16'h0, 1'b0);
      step(16'h0005, 16'h0, 1'b0);
      step(16'hEC10, 16'h0, 1'b0);
      step(16'hE308, 16'h0, 1'b0);
      step(16'hFDC8, 16'h7, 1'b0);
      step(16'h0064, 16'h0, 1'b0);
      step(16'hEA87, 16'h0, 1'b0);
      step(16'h0005, 16'h0, 1'b0);
      step(16'hEC10, 16'h0, 1'b0);
      step(16'h0032, 16'h0, 1'b0);
      step(16'hE301, 16'h0, 1'b0);
      step(16'hE302, 16'h0, 1'b0);
      step(16'hEA90, 16'h0, 1'b0);
      step(16'h0028, 16'h0, 1'b0);
      step(16'hE302, 16'h0, 1'b0);
      step(16'h0010, 16'h0, 1'b0);
      step(16'hFC27, 16'h0020, 1'b0);
      step(16'h0010, 16'h0, 1'b0);
      step(16'hFC27, 16'h0020, 1'b1);
      step(16'hEEA0, 16'h0, 1'b0);
      step(16'hEA87, 16'h0, 1'b0);
      step(16'h0003, 16'h0, 1'b0);
      for (int i = 0; i < 40; i++)
         step(16'($urandom), 16'($urandom), $urandom_range(0, 7) == 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/hack_cpu.md
HACK_CPU -- requirements
Module: hack_cpu

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; ports are named clk and reset as in the existing codebase.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous active-high reset; affects PC only.
REQ-004 inM  input  16  data word read from memory at address addressM.
REQ-005 instruction  input  16  current instruction word.
REQ-006 outM  output  16  combinational ALU result; the memory write data.
REQ-007 writeM  output  1  combinational memory write enable.
REQ-008 addressM  output  16  current A register value.
REQ-009 pc  output  16  current program counter value.

Function
REQ-010 The block SHALL hold three 16-bit registers: A (driven on addressM), D (internal) and PC (driven on pc). All three SHALL update on the rising edge of clk.
REQ-011 A-instruction (instruction[15]=0): A SHALL load instruction; D SHALL hold; writeM SHALL be 0; no jump; outM is don't-care.
REQ-012 C-instruction (instruction[15]=1): bits [14:13] SHALL be ignored.
REQ-013 C-instruction ALU inputs: x=D; y=inM if instruction[12]=1, else y=A.
REQ-014 ALU control bits: zx=[11], nx=[10], zy=[9], ny=[8], f=[6+1]=[7], no=[6].
REQ-015 ALU operation order:
- zx forces x=0; then nx inverts x.
- zy forces y=0; then ny inverts y.
- f=1 gives x+y (16-bit, wraps, carry discarded); f=0 gives x&y.
- no inverts the result.
REQ-016 outM SHALL equal the ALU result combinationally.
REQ-017 Flags: zr=(outM==0); ng=outM[15].
REQ-018 Destinations:
- instruction[5]=1: A loads the ALU result.
- instruction[4]=1: D loads the ALU result.
- writeM SHALL equal instruction[3] (combinational).
REQ-019 Jump condition: jmp = C-instruction AND ((ng & [2]) | (zr & [1]) | (!ng & !zr & [0])).
REQ-020 PC next value, in priority order:
- reset=1: 0.
- else jmp=1: A value before this edge's update.
- else: PC+1, wrapping 0xFFFF to 0x0000.
REQ-021 When A is both written and used as the jump target in the same cycle, the jump SHALL use the old A value.
REQ-022 ALU reads of A and D SHALL use the current (pre-edge) register values.
REQ-023 The block SHALL have no internal memory and no multi-cycle states; every instruction completes in one cycle.

Reset
REQ-024 While reset=1, PC SHALL load 0 on each rising edge regardless of jmp.
REQ-025 A and D SHALL NOT be reset and SHALL keep executing instruction writes during reset.
REQ-026 A, D and PC SHALL power up to 0 in simulation (register initial value).
REQ-027 writeM and outM SHALL remain combinational during reset; memory writes are not suppressed.

Verification
REQ-028 Reset and count: hold reset=1 for 3 cycles → pc=0; release reset with A-instructions → pc=1,2,3 on successive edges.
REQ-029 A-instruction and D=A:
- instruction=0x1234 → next cycle addressM=0x1234, writeM=0.
- @5 then 0xEC10 (D=A) → D=5.
- Then 0xE308 (M=D) → outM=0x0005, writeM=1.
REQ-030 M=M+1: instruction=0xFDC8 with inM=7 → outM=8, writeM=1; A and D unchanged.
REQ-031 Unconditional jump: @100 then 0xEA87 (0;JMP) → next pc=100; writeM=0.
REQ-032 Conditional jumps:
- D=5, 0xE301 (D;JGT) → pc=A.
- D=5, 0xE302 (D;JEQ) → pc=pc+1.
- D=0, 0xE302 → pc=A.
REQ-033 Jump priority and ordering:
- A=0x0010, inM=0x0020, 0xFC27 (A=M;JMP) → pc=0x0010 and A=0x0020 after the edge.
- Same instruction with reset=1 → pc=0 and A=0x0020.
